// File: rtl/elastic_buffer.sv
// DEPTH-entry valid/ready elastic buffer with flush and occupancy/high-water status.
// Latency: 1 cycle from accepted beat to out_valid when empty; one beat per cycle sustained.
// Backpressure: in_ready depends only on registered occupancy and flush, never on out_ready.
module elastic_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    hwm
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    hwm_q, hwm_d;
    logic             push, pop;

    assign in_ready  = (count_q != FULL) & ~flush;
    assign out_valid = (count_q != '0) & ~flush;
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign hwm       = hwm_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hwm_d    = hwm_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            hwm_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hwm_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hwm_q    <= hwm_d;
        end
    end

    // Flush leaves storage alone; only the pointers and counters are cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_elastic_buffer.sv
// Bench for elastic_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_elastic_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] in_data, out_data;
    logic [CW-1:0]    count, hwm;

    always #5 clk = ~clk;

    elastic_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .hwm(hwm)
    );

    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] got[$];
    int               mhwm;
    int               n_chk  = 0;
    int               n_pass = 0;
    bit               last_push;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle: compare outputs to the model mid-cycle, then advance the model at the edge.
    task automatic step(input string tag);
        bit               mir, mov, psh, pp;
        logic [WIDTH-1:0] d;
        @(negedge clk);
        mir = (mq.size() < DEPTH) && !flush;
        mov = (mq.size() != 0) && !flush;
        chk({tag, ".in_ready"},  64'(in_ready),  64'(mir));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(mov));
        chk({tag, ".count"},     64'(count),     64'(mq.size()));
        chk({tag, ".hwm"},       64'(hwm),       64'(mhwm));
        if (mov) chk({tag, ".out_data"}, 64'(out_data), 64'(mq[0]));
        psh = in_valid && mir;
        pp  = mov && out_ready;
        d   = in_data;
        if (pp) got.push_back(out_data);
        last_push = psh;
        @(posedge clk);
        if (flush) begin
            mq.delete();
            mhwm = 0;
        end else begin
            if (pp)  void'(mq.pop_front());
            if (psh) mq.push_back(d);
            if (mq.size() > mhwm) mhwm = mq.size();
        end
        #1;
    endtask

    task automatic check_got(input string tag, input int n, input logic [WIDTH-1:0] first, input logic [WIDTH-1:0] incr);
        chk({tag, ".n"}, 64'(got.size()), 64'(n));
        for (int i = 0; i < n; i++)
            chk({tag, ".order"}, 64'((i < got.size()) ? got[i] : '1), 64'(first + incr * i));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
        mhwm = 0;

        // Reset held with a beat presented: nothing may be stored
        #22;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.in_ready",  64'(in_ready),  64'd1);
        chk("rst.count",     64'(count),     64'd0);
        chk("rst.hwm",       64'(hwm),       64'd0);
        chk("rst.out_data",  64'(out_data),  64'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk); #1;
        step("post_rst");
        chk("post_rst.count", 64'(count), 64'd0);

        // Stall then drain
        got.delete();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hAAAA;
        step("stall");
        in_data = 32'hBBBB;
        step("stall");
        in_valid = 1'b0;
        step("stall_hold");
        step("stall_hold");
        chk("stall.count",    64'(count),    64'd2);
        chk("stall.out_data", 64'(out_data), 64'hAAAA);
        out_ready = 1'b1;
        repeat (3) step("drain");
        check_got("drain", 2, 32'hAAAA, 32'h1111);
        chk("drain.count", 64'(count), 64'd0);
        chk("drain.hwm",   64'(hwm),   64'd2);

        // Fill to full, fifth beat waits for a pop
        got.delete();
        out_ready = 1'b0; idx = 1;
        for (int c = 0; c < 8 && idx <= 4; c++) begin
            in_valid = 1'b1; in_data = idx;
            step("fill");
            if (last_push) idx++;
        end
        in_data = 5;
        #1;
        chk("full.in_ready", 64'(in_ready), 64'd0);
        chk("full.count",    64'(count),    64'd4);
        out_ready = 1'b1;
        step("full_pop");
        chk("full_pop.in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
        step("push5");
        chk("push5.count", 64'(count), 64'd4);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) step("fill_drain");
        check_got("fill", 5, 1, 1);

        // Streaming across pointer wrap, starting from a flushed buffer
        flush = 1'b1;
        step("pre_stream_flush");
        flush = 1'b0;
        got.delete();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            in_data = i;
            step("stream");
            chk("stream.cnt_le1", 64'(count <= 1), 64'd1);
        end
        in_valid = 1'b0;
        step("stream_tail");
        check_got("stream", 3 * DEPTH, 0, 1);
        chk("stream.hwm", 64'(hwm), 64'd1);

        // Flush with traffic presented on both sides
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h100 + i;
            step("flush_load");
        end
        got.delete();
        flush = 1'b1; in_data = 32'h99; out_ready = 1'b1;
        #1;
        chk("flush.in_ready",  64'(in_ready),  64'd0);
        chk("flush.out_valid", 64'(out_valid), 64'd0);
        step("flush");
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush.delivered", 64'(got.size()), 64'd0);
        chk("flush.count",     64'(count),      64'd0);
        chk("flush.hwm",       64'(hwm),        64'd0);
        step("post_flush");

        // Asynchronous reset between edges with three beats stored
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'h200 + i;
            step("arst_load");
        end
        in_valid = 1'b0;
        chk("arst.pre_count", 64'(count), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 64'(out_valid), 64'd0);
        chk("arst.count",     64'(count),     64'd0);
        chk("arst.hwm",       64'(hwm),       64'd0);
        chk("arst.in_ready",  64'(in_ready),  64'd1);
        chk("arst.out_data",  64'(out_data),  64'd0);
        mq.delete(); mhwm = 0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        step("post_arst");

        // Random traffic; upstream holds a beat until it is accepted
        in_valid = 1'b0; last_push = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (!(in_valid && !last_push)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            step("rand");
        end
        flush = 1'b0; in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
